// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_core
// Brief    : Multi-cycle MIPS-I subset core. One FSM walks each instruction
//            through FETCH / DECODE / EXEC / MEM / WB. Instruction and data
//            memories are external and reached through req/ack handshakes,
//            so memories with wait states are supported. The core holds the
//            register file, ALU, decoder and PC.
//
//            Supported: add sub and or slt (R-type), addi, lw, sw, beq, bne, j.
//            Any other opcode/funct halts the core with err_code 01.
//            A request that waits TIMEOUT cycles without ack halts the core
//            with err_code 10 (imem) or 11 (dmem). TIMEOUT = 0 disables this.
//
// Ports    : clkin       core clock, rising edge
//            reset       asynchronous reset, active low
//            imem_req    instruction fetch request
//            imem_addr   instruction word address (pc[IMEM_AW+1:2])
//            imem_rdata  instruction word, valid with imem_ack
//            imem_ack    fetch completion
//            dmem_req    data access request
//            dmem_we     1 = store, 0 = load
//            dmem_addr   data word address (alu result[DMEM_AW+1:2])
//            dmem_wdata  store data (rt)
//            dmem_rdata  load data, valid with dmem_ack
//            dmem_ack    data completion
//            pc          current program counter
//            retire      high in the cycle an instruction completes
//            halted      core stopped, only reset restarts it
//            err_code    00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
//
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_core #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 7,
    parameter int unsigned DMEM_AW  = 6,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               clkin,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ack,
    output logic [31:0]        pc,
    output logic               retire,
    output logic               halted,
    output logic [1:0]         err_code
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_IMEM    = 2'b10;
    localparam logic [1:0] c_ERR_DMEM    = 2'b11;

    // Wide enough to hold TIMEOUT-1; at least one bit when disabled.
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_ir;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [31:0]         r_alures;
    logic                r_imem_req;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [DMEM_AW-1:0]  r_dmem_addr;
    logic [31:0]         r_dmem_wdata;
    logic                r_halted;
    logic [1:0]          r_err;
    logic [c_TW-1:0]     r_tmo;
    logic [31:0]         r_regs [0:31];

    // ------------------------------------------------------------------
    // Instruction fields and decode
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [31:0] w_br_off;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [4:0]  w_dest;

    logic w_is_rtype;
    logic w_is_addi;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_bne;
    logic w_is_j;
    logic w_is_flow;
    logic w_funct_ok;
    logic w_legal;
    logic w_br_taken;
    logic w_tmo_hit;

    logic [31:0] w_alu;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_br_off   = {w_imm_sext[29:0], 2'b00};

    // $0 always reads as zero regardless of array contents.
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

    assign w_is_rtype = (w_op == c_OP_RTYPE);
    assign w_is_addi  = (w_op == c_OP_ADDI);
    assign w_is_lw    = (w_op == c_OP_LW);
    assign w_is_sw    = (w_op == c_OP_SW);
    assign w_is_beq   = (w_op == c_OP_BEQ);
    assign w_is_bne   = (w_op == c_OP_BNE);
    assign w_is_j     = (w_op == c_OP_J);
    assign w_is_flow  = w_is_beq | w_is_bne | w_is_j;

    assign w_funct_ok = (w_funct == c_FN_ADD) | (w_funct == c_FN_SUB) |
                        (w_funct == c_FN_AND) | (w_funct == c_FN_OR)  |
                        (w_funct == c_FN_SLT);

    assign w_legal = (w_is_rtype & w_funct_ok) | w_is_addi | w_is_lw |
                     w_is_sw | w_is_flow;

    assign w_br_taken = (w_is_beq & (w_rs_val == w_rt_val)) |
                        (w_is_bne & (w_rs_val != w_rt_val));

    assign w_dest = w_is_rtype ? w_rd : w_rt;

    // Counter sits at k-1 during the k-th request cycle, so the hit fires on
    // the TIMEOUT-th cycle without ack; an ack in that same cycle wins.
    assign w_tmo_hit = (TIMEOUT != 0) && ((32'(r_tmo) + 32'd1) >= TIMEOUT);

    // ------------------------------------------------------------------
    // ALU: R-type by funct, everything else is rs + sext(imm)
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = r_a + w_imm_sext;
        if (w_is_rtype) begin
            case (w_funct)
                c_FN_ADD: w_alu = r_a + r_b;
                c_FN_SUB: w_alu = r_a - r_b;
                c_FN_AND: w_alu = r_a & r_b;
                c_FN_OR:  w_alu = r_a | r_b;
                c_FN_SLT: w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
                default:  w_alu = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file; writes to $0 are dropped
    // ------------------------------------------------------------------
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if ((r_state == S_WB) && (w_dest != 5'd0)) begin
            r_regs[w_dest] <= r_alures;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    //
    // Request outputs are registered and raised on the transition into
    // FETCH/MEM, so a zero-wait memory completes in the first cycle of the
    // state. Straight out of reset FETCH spends one cycle raising imem_req.
    //
    // Branch/jump targets are resolved at the end of DECODE, so pc already
    // holds the next PC during EXEC, the cycle in which those retire.
    // ------------------------------------------------------------------
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_pc         <= PC_RESET;
            r_ir         <= 32'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_alures     <= 32'd0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= 32'd0;
            r_halted     <= 1'b0;
            r_err        <= 2'b00;
            r_tmo        <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                        r_tmo      <= '0;
                    end else if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_pc       <= r_pc + 32'd4;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else if (w_tmo_hit) begin
                        r_imem_req <= 1'b0;
                        r_halted   <= 1'b1;
                        r_err      <= c_ERR_IMEM;
                        r_state    <= S_HALT;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end

                S_DECODE: begin
                    if (!w_legal) begin
                        r_halted <= 1'b1;
                        r_err    <= c_ERR_ILLEGAL;
                        r_state  <= S_HALT;
                    end else begin
                        r_a <= w_rs_val;
                        r_b <= w_rt_val;
                        if (w_is_j) begin
                            r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        end else if (w_br_taken) begin
                            // r_pc already holds the address after the branch
                            r_pc <= r_pc + w_br_off;
                        end
                        r_state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (w_is_flow) begin
                        r_imem_req <= 1'b1;
                        r_tmo      <= '0;
                        r_state    <= S_FETCH;
                    end else if (w_is_lw || w_is_sw) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_is_sw;
                        r_dmem_addr  <= w_alu[DMEM_AW+1:2];
                        r_dmem_wdata <= r_b;
                        r_tmo        <= '0;
                        r_state      <= S_MEM;
                    end else begin
                        r_alures <= w_alu;
                        r_state  <= S_WB;
                    end
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_imem_req <= 1'b1;
                            r_tmo      <= '0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_alures <= dmem_rdata;
                            r_state  <= S_WB;
                        end
                    end else if (w_tmo_hit) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_halted   <= 1'b1;
                        r_err      <= c_ERR_DMEM;
                        r_state    <= S_HALT;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end

                S_WB: begin
                    r_imem_req <= 1'b1;
                    r_tmo      <= '0;
                    r_state    <= S_FETCH;
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_halted   <= 1'b1;
                    r_state    <= S_HALT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc[IMEM_AW+1:2];
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign pc         = r_pc;
    assign halted     = r_halted;
    assign err_code   = r_err;

    // A store completes on its ack, so retire cannot be a registered pulse.
    assign retire = (r_state == S_WB) ||
                    ((r_state == S_EXEC) && w_is_flow) ||
                    ((r_state == S_MEM) && r_dmem_we && dmem_ack);

endmodule
`default_nettype wire
